// File: rtl/ex_pkg.sv
// Shared types and field layout for the execute stage of the 16-bit pipeline.
// Opcode/selector encodings plus packed views of the ID/EX and EX/MEM bundles.
package ex_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 32;
  localparam int FLAG_W  = 3;
  localparam int IDEX_W  = 91;
  localparam int EXMEM_W = 76;

  localparam int ZF_BIT = 0;
  localparam int CF_BIT = 1;
  localparam int NF_BIT = 2;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SHL  = 3'd4,
    ALU_SHR  = 3'd5,
    ALU_PASS = 3'd6,
    ALU_NOT  = 3'd7
  } alu_op_e;

  // With OPS=1 only the low two codes do arithmetic; the rest pass A.
  localparam logic [2:0] OPS1_INC = 3'd0;
  localparam logic [2:0] OPS1_DEC = 3'd1;

  typedef enum logic [1:0] {
    FD_CLRC = 2'b00,
    FD_SETC = 2'b01,
    FD_NONE = 2'b10,
    FD_ALU  = 2'b11
  } fd_e;

  typedef enum logic [1:0] {
    FGS_ALWAYS = 2'b00,
    FGS_ZF     = 2'b01,
    FGS_CF     = 2'b10,
    FGS_NF     = 2'b11
  } fgs_e;

  // Declared MSB first so the packed layout matches the bus bit map.
  typedef struct packed {
    logic        stack_flags;  // 90
    logic        stack_pc;     // 89
    logic        imm;          // 88
    logic [2:0]  src_address;  // 87:85
    logic        jwsp;         // 84
    logic [31:0] pc;           // 83:52
    logic [1:0]  fgs;          // 51:50
    logic        spop;         // 49
    logic        sp;           // 48
    logic        jmp;          // 47
    logic        wb;           // 46
    logic        mw;           // 45
    logic        mr;           // 44
    logic [2:0]  wb_address;   // 43:41
    logic [15:0] data2;        // 40:25
    logic [15:0] data1;        // 24:9
    logic [1:0]  fd;           // 8:7
    logic        alu;          // 6
    logic [2:0]  alu_op;       // 5:3
    logic        ops;          // 2
    logic        iow;          // 1
    logic        ior;          // 0
  } idex_t;

  typedef struct packed {
    logic [2:0]  final_flags;  // 75:73
    logic        stack_flags;  // 72
    logic        stack_pc;     // 71
    logic        jwsp;         // 70
    logic [31:0] address;      // 69:38
    logic        wb;           // 37
    logic        mw;           // 36
    logic        mr;           // 35
    logic [2:0]  wb_address;   // 34:32
    logic [31:0] data;         // 31:0
  } exmem_t;

  function automatic logic jump_cond(input logic [1:0] fgs, input logic [2:0] flags);
    logic cond;
    case (fgs)
      FGS_ALWAYS: cond = 1'b1;
      FGS_ZF:     cond = flags[ZF_BIT];
      FGS_CF:     cond = flags[CF_BIT];
      FGS_NF:     cond = flags[NF_BIT];
      default:    cond = 1'b0;
    endcase
    return cond;
  endfunction

  // Flag bit consumed by a taken conditional jump; zero mask for unconditional.
  function automatic logic [2:0] jump_clear_mask(input logic [1:0] fgs);
    logic [2:0] mask;
    case (fgs)
      FGS_ZF:  mask = 3'b001;
      FGS_CF:  mask = 3'b010;
      FGS_NF:  mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/alu16.sv
// 16-bit ALU for the execute stage. c_upd marks operations that define the
// carry; otherwise the caller keeps its previous carry flag.
module alu16
  import ex_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  alu_op,
  input  logic        ops,
  output logic [15:0] res,
  output logic        c,
  output logic        c_upd,
  output logic        z,
  output logic        n
);

  logic [16:0] sum_s;
  logic [16:0] inc_s;
  logic [31:0] shl_wide_s;
  logic [31:0] shr_wide_s;
  logic        big_shift_s;
  logic        zero_shift_s;

  // Shared adders and shifters; shift distance is only meaningful up to 16.
  always_comb begin
    sum_s        = {1'b0, a} + {1'b0, b};
    inc_s        = {1'b0, a} + 17'd1;
    shl_wide_s   = {16'd0, a} << b[4:0];
    shr_wide_s   = {a, 16'd0} >> b[4:0];
    big_shift_s  = (b > 16'd16);
    zero_shift_s = (b == 16'd0);
  end

  // Operation select, result plus carry behaviour per opcode.
  always_comb begin
    res   = a;
    c     = 1'b0;
    c_upd = 1'b0;
    if (ops == 1'b0) begin
      case (alu_op)
        ALU_ADD: begin
          res   = sum_s[15:0];
          c     = sum_s[16];
          c_upd = 1'b1;
        end
        ALU_SUB: begin
          res   = a - b;
          c     = (a < b);
          c_upd = 1'b1;
        end
        ALU_AND:  res = a & b;
        ALU_OR:   res = a | b;
        ALU_SHL: begin
          if (zero_shift_s) begin
            res = a;
          end else if (big_shift_s) begin
            res   = 16'd0;
            c_upd = 1'b1;
          end else begin
            res   = shl_wide_s[15:0];
            c     = shl_wide_s[16];
            c_upd = 1'b1;
          end
        end
        ALU_SHR: begin
          if (zero_shift_s) begin
            res = a;
          end else if (big_shift_s) begin
            res   = 16'd0;
            c_upd = 1'b1;
          end else begin
            res   = shr_wide_s[31:16];
            c     = shr_wide_s[15];
            c_upd = 1'b1;
          end
        end
        ALU_PASS: res = a;
        ALU_NOT:  res = ~a;
        default:  res = a;
      endcase
    end else begin
      case (alu_op)
        OPS1_INC: begin
          res   = inc_s[15:0];
          c     = inc_s[16];
          c_upd = 1'b1;
        end
        OPS1_DEC: begin
          res   = a - 16'd1;
          c     = (a == 16'd0);
          c_upd = 1'b1;
        end
        default: res = a;
      endcase
    end
  end

  assign z = (res == 16'd0);
  assign n = res[15];

endmodule

// File: rtl/execution_unit.sv
// Execute stage: operand select, ALU, flags, I/O ports, stack pointer and
// branch resolution, with the flag register and EX/MEM register held here.
module execution_unit
  import ex_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [IDEX_W-1:0]   IDEX,
  input  logic [DATA_W-1:0]   Immediate_Value,
  input  logic [1:0]          Fwd_Sel,
  input  logic [DATA_W-1:0]   Fwd_Data1,
  input  logic [DATA_W-1:0]   Fwd_Data2,
  input  logic [FLAG_W-1:0]   Flags_From_Memory,
  input  logic                Flags_Restore,
  input  logic [DATA_W-1:0]   INPUT_PORT,
  input  logic [DATA_W-1:0]   OUTPUT_PORT_Input,
  input  logic [ADDR_W-1:0]   Stack_Pointer,
  output logic [EXMEM_W-1:0]  EXMEM,
  output logic [FLAG_W-1:0]   Flags,
  output logic [DATA_W-1:0]   OUTPUT_PORT,
  output logic [ADDR_W-1:0]   Stack_Pointer_Out,
  output logic                Taken_Jump,
  output logic                To_PC_Selector
);

  idex_t              idex_s;
  exmem_t             exmem_next_s;
  exmem_t             exmem_r;
  logic [FLAG_W-1:0]  flags_r;
  logic [FLAG_W-1:0]  flags_alu_s;
  logic [FLAG_W-1:0]  final_flags_s;
  logic [DATA_W-1:0]  a_s;
  logic [DATA_W-1:0]  b_s;
  logic [DATA_W-1:0]  b2_s;
  logic [DATA_W-1:0]  alu_res_s;
  logic               alu_c_s;
  logic               alu_c_upd_s;
  logic               alu_z_s;
  logic               alu_n_s;
  logic               taken_s;
  logic [ADDR_W-1:0]  stack_step_s;
  logic [ADDR_W-1:0]  sp_next_s;
  logic [ADDR_W-1:0]  stack_addr_s;
  logic [ADDR_W-1:0]  data_s;

  assign idex_s = idex_t'(IDEX);

  // Operand forwarding and immediate substitution for the second operand.
  always_comb begin
    a_s  = Fwd_Sel[0] ? Fwd_Data1 : idex_s.data1;
    b_s  = Fwd_Sel[1] ? Fwd_Data2 : idex_s.data2;
    b2_s = idex_s.imm ? Immediate_Value : b_s;
  end

  alu16 u_alu (
    .a      (a_s),
    .b      (b2_s),
    .alu_op (idex_s.alu_op),
    .ops    (idex_s.ops),
    .res    (alu_res_s),
    .c      (alu_c_s),
    .c_upd  (alu_c_upd_s),
    .z      (alu_z_s),
    .n      (alu_n_s)
  );

  // Stack pointer update: pushes post-decrement, pops pre-increment.
  always_comb begin
    stack_step_s = idex_s.stack_pc ? 32'd2 : 32'd1;
    if (idex_s.sp) begin
      if (idex_s.spop) begin
        sp_next_s    = Stack_Pointer + stack_step_s;
        stack_addr_s = sp_next_s;
      end else begin
        sp_next_s    = Stack_Pointer - stack_step_s;
        stack_addr_s = Stack_Pointer;
      end
    end else begin
      sp_next_s    = Stack_Pointer;
      stack_addr_s = {16'd0, a_s};
    end
  end

  // Write-back data source priority.
  always_comb begin
    if (idex_s.ior) begin
      data_s = {16'd0, INPUT_PORT};
    end else if (idex_s.alu) begin
      data_s = {16'd0, alu_res_s};
    end else if (idex_s.stack_pc) begin
      data_s = idex_s.pc;
    end else if (idex_s.stack_flags) begin
      data_s = {29'd0, flags_r};
    end else if (idex_s.imm) begin
      data_s = {16'd0, Immediate_Value};
    end else begin
      data_s = {16'd0, b_s};
    end
  end

  // Branches test the flags as registered, before this instruction's update.
  assign taken_s = idex_s.jmp & jump_cond(idex_s.fgs, flags_r);

  // Flag next-state: ALU/SETC/CLRC effect, then jump clear, then RTI restore.
  always_comb begin
    flags_alu_s = flags_r;
    if (idex_s.alu) begin
      case (idex_s.fd)
        FD_ALU: begin
          flags_alu_s[ZF_BIT] = alu_z_s;
          flags_alu_s[NF_BIT] = alu_n_s;
          flags_alu_s[CF_BIT] = alu_c_upd_s ? alu_c_s : flags_r[CF_BIT];
        end
        FD_SETC: flags_alu_s[CF_BIT] = 1'b1;
        FD_CLRC: flags_alu_s[CF_BIT] = 1'b0;
        default: flags_alu_s = flags_r;
      endcase
    end else if (idex_s.fd == FD_SETC) begin
      flags_alu_s[CF_BIT] = 1'b1;
    end else begin
      flags_alu_s = flags_r;
    end

    if (Flags_Restore) begin
      final_flags_s = Flags_From_Memory;
    end else if (taken_s) begin
      final_flags_s = flags_alu_s & ~jump_clear_mask(idex_s.fgs);
    end else begin
      final_flags_s = flags_alu_s;
    end
  end

  // Assemble the next EX/MEM bundle.
  always_comb begin
    exmem_next_s             = '0;
    exmem_next_s.data        = data_s;
    exmem_next_s.wb_address  = idex_s.wb_address;
    exmem_next_s.mr          = idex_s.mr;
    exmem_next_s.mw          = idex_s.mw;
    exmem_next_s.wb          = idex_s.wb;
    exmem_next_s.address     = stack_addr_s;
    exmem_next_s.jwsp        = idex_s.jwsp;
    exmem_next_s.stack_pc    = idex_s.stack_pc;
    exmem_next_s.stack_flags = idex_s.stack_flags;
    exmem_next_s.final_flags = final_flags_s;
  end

  // Flag register and EX/MEM register share one load edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      exmem_r <= '0;
      flags_r <= 3'b000;
    end else begin
      exmem_r <= exmem_next_s;
      flags_r <= final_flags_s;
    end
  end

  assign EXMEM             = exmem_r;
  assign Flags             = flags_r;
  assign OUTPUT_PORT       = idex_s.iow ? a_s : OUTPUT_PORT_Input;
  assign Stack_Pointer_Out = sp_next_s;
  assign Taken_Jump        = taken_s;
  assign To_PC_Selector    = taken_s;

endmodule

// File: tb/tb_execution_unit.sv
// Scoreboard bench for execution_unit: a driver computes expected results from
// an arithmetic reference model; a monitor compares the registered outputs.
module tb_execution_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [90:0] ix;
  logic [15:0] imm, fd1, fd2, in_port, out_in;
  logic [1:0]  fsel;
  logic [2:0]  mem_flags;
  logic        restore;
  logic [31:0] sp;
  logic [75:0] exmem;
  logic [2:0]  flags;
  logic [15:0] out_port;
  logic [31:0] sp_out;
  logic        taken, to_pc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [75:0] exm; logic [2:0] fl; } exp_t;
  exp_t sbq[$];
  logic [2:0] m_flags;

  always #5 clk = ~clk;

  execution_unit dut (
    .clk(clk), .reset(reset), .IDEX(ix), .Immediate_Value(imm), .Fwd_Sel(fsel),
    .Fwd_Data1(fd1), .Fwd_Data2(fd2), .Flags_From_Memory(mem_flags),
    .Flags_Restore(restore), .INPUT_PORT(in_port), .OUTPUT_PORT_Input(out_in),
    .Stack_Pointer(sp), .EXMEM(exmem), .Flags(flags), .OUTPUT_PORT(out_port),
    .Stack_Pointer_Out(sp_out), .Taken_Jump(taken), .To_PC_Selector(to_pc)
  );

  task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    ix = '0; imm = 16'd0; fd1 = 16'd0; fd2 = 16'd0; fsel = 2'b00; mem_flags = 3'b000;
    restore = 1'b0; in_port = 16'd0; out_in = 16'd0; sp = 32'h0000_1000; reset = 1'b0;
  endtask

  task automatic alu_set(input int op, input bit ops, input int a, input int b,
                         input bit use_imm, input int immv);
    clr();
    ix[6] = 1'b1; ix[8:7] = 2'b11; ix[5:3] = 3'(op); ix[2] = ops;
    ix[24:9] = 16'(a); ix[40:25] = 16'(b); ix[88] = use_imm; imm = 16'(immv);
  endtask

  // Reference model from the instruction-level rules, then drive and check comb outputs.
  task automatic issue();
    int unsigned ai, bi, r;
    bit          cdef, cv, cond;
    logic [15:0] a, b, b2, res;
    logic [2:0]  nf;
    logic [31:0] data, addr, spn, n;
    exp_t        e;
    a  = fsel[0] ? fd1 : ix[24:9];
    b  = fsel[1] ? fd2 : ix[40:25];
    b2 = ix[88] ? imm : b;
    ai = a; bi = b2; r = ai; cdef = 0; cv = 0;
    if (!ix[2]) begin
      case (ix[5:3])
        3'd0: begin r = ai + bi; cv = (r > 65535); cdef = 1; end
        3'd1: begin r = ai + 65536 - bi; cv = (ai < bi); cdef = 1; end
        3'd2: r = ai & bi;
        3'd3: r = ai | bi;
        3'd4: if (bi == 0) r = ai;
              else if (bi <= 16) begin r = ai << bi; cv = (r >> 16) & 1; cdef = 1; end
              else begin r = 0; cdef = 1; end
        3'd5: if (bi == 0) r = ai;
              else if (bi <= 16) begin r = ai >> bi; cv = (ai >> (bi - 1)) & 1; cdef = 1; end
              else begin r = 0; cdef = 1; end
        3'd6: r = ai;
        default: r = ~ai;
      endcase
    end else begin
      case (ix[5:3])
        3'd0: begin r = ai + 1; cv = (r > 65535); cdef = 1; end
        3'd1: begin r = ai + 65535; cv = (ai == 0); cdef = 1; end
        default: r = ai;
      endcase
    end
    res = r[15:0];

    nf = m_flags;
    if (ix[6]) begin
      if (ix[8:7] == 2'b11) begin
        nf[0] = (res == 16'd0); nf[2] = res[15];
        if (cdef) nf[1] = cv;
      end else if (ix[8:7] == 2'b01) nf[1] = 1'b1;
      else if (ix[8:7] == 2'b00) nf[1] = 1'b0;
    end else if (ix[8:7] == 2'b01) nf[1] = 1'b1;

    case (ix[51:50])
      2'd0: cond = 1;
      2'd1: cond = m_flags[0];
      2'd2: cond = m_flags[1];
      default: cond = m_flags[2];
    endcase
    cond = cond & ix[47];
    if (cond && ix[51:50] != 2'd0) nf[int'(ix[51:50]) - 1] = 1'b0;
    if (restore) nf = mem_flags;

    if (ix[0]) data = {16'd0, in_port};
    else if (ix[6]) data = {16'd0, res};
    else if (ix[89]) data = ix[83:52];
    else if (ix[90]) data = {29'd0, m_flags};
    else if (ix[88]) data = {16'd0, imm};
    else data = {16'd0, b};

    n = ix[89] ? 32'd2 : 32'd1;
    spn = sp; addr = {16'd0, a};
    if (ix[48] && ix[49]) begin spn = sp + n; addr = spn; end
    else if (ix[48]) begin spn = sp - n; addr = sp; end

    e.exm = {nf, ix[90], ix[89], ix[84], addr, ix[46], ix[45], ix[44], ix[43:41], data};
    e.fl  = nf;
    if (reset) begin e.exm = '0; e.fl = 3'b000; end
    sbq.push_back(e);
    m_flags = e.fl;

    #1;
    chk("taken_jump", 76'(taken), 76'(cond));
    chk("to_pc_sel", 76'(to_pc), 76'(cond));
    chk("sp_out", 76'(sp_out), 76'(spn));
    chk("output_port", 76'(out_port), 76'(ix[1] ? a : out_in));
  endtask

  // Monitor: every edge after an issue, pop the expected response and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("exmem", exmem, e.exm);
        chk("flags", 76'(flags), 76'(e.fl));
      end
    end
  end

  initial begin
    m_flags = 3'b000;
    clr();
    reset = 1'b1;
    @(negedge clk); issue();
    @(negedge clk); clr(); ix[40:25] = 16'd127; ix[8:7] = 2'b10; ix[46] = 1'b1; ix[43:41] = 3'd7; issue();
    @(negedge clk); alu_set(0, 0, 7, 8, 0, 0);        issue();
    @(negedge clk); alu_set(1, 0, 23, 8, 0, 0);       issue();
    @(negedge clk); alu_set(1, 0, 8, 23, 0, 0);       issue();
    @(negedge clk); alu_set(2, 0, 5, 10, 0, 0);       issue();
    @(negedge clk); alu_set(3, 0, 5, 10, 0, 0);       issue();
    @(negedge clk); alu_set(7, 0, 15, 0, 0, 0);       issue();
    @(negedge clk); alu_set(4, 0, 16'hFFFF, 0, 1, 16); issue();
    @(negedge clk); alu_set(5, 0, 16'hFFFF, 15, 0, 0); issue();
    @(negedge clk); alu_set(4, 0, 16'hFFFF, 15, 0, 0); issue();
    @(negedge clk); alu_set(4, 0, 16'h1234, 17, 0, 0); issue();
    @(negedge clk); alu_set(0, 1, 7, 0, 0, 0);        issue();
    @(negedge clk); alu_set(1, 1, 7, 0, 0, 0);        issue();
    @(negedge clk); clr(); ix[8:7] = 2'b01; issue();
    @(negedge clk); clr(); ix[47] = 1'b1; ix[51:50] = 2'b10; ix[24:9] = 16'h0040; issue();
    @(negedge clk); alu_set(6, 0, 3, 0, 0, 0); ix[8:7] = 2'b00; issue();
    @(negedge clk); clr(); ix[0] = 1'b1; in_port = 16'd12; issue();
    @(negedge clk); clr(); ix[48] = 1'b1; ix[89] = 1'b1; ix[83:52] = 32'hCAFE_0010; issue();
    @(negedge clk); clr(); ix[48] = 1'b1; ix[49] = 1'b1; issue();
    @(negedge clk); clr(); restore = 1'b1; mem_flags = 3'b101; issue();

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      clr();
      ix = {$urandom, $urandom, $urandom};
      ix[0] = ($urandom_range(0, 7) == 0);
      fsel = 2'($urandom);
      fd1 = 16'($urandom); fd2 = 16'($urandom);
      imm = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if ($urandom_range(0, 3) == 0) ix[40:25] = 16'($urandom_range(0, 20));
      mem_flags = 3'($urandom);
      restore = ($urandom_range(0, 7) == 0);
      in_port = 16'($urandom); out_in = 16'($urandom); sp = $urandom;
      reset = (i == 200);
      issue();
    end

    @(negedge clk); clr();
    @(posedge clk); #2;
    chk("scoreboard_drain", 76'(sbq.size()), 76'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
